// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit multi-cycle CPU: opcodes, FSM states,
// display page indices and the default program image.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_OPND  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [2:0] PAGE_R0    = 3'd0;
  localparam logic [2:0] PAGE_R1    = 3'd1;
  localparam logic [2:0] PAGE_R2    = 3'd2;
  localparam logic [2:0] PAGE_R3    = 3'd3;
  localparam logic [2:0] PAGE_PC    = 3'd4;
  localparam logic [2:0] PAGE_IR    = 3'd5;
  localparam logic [2:0] PAGE_ALR   = 3'd6;
  localparam logic [2:0] PAGE_FLAGS = 3'd7;

  // Unprogrammed addresses read as 0x00, which decodes as NOP.
  function automatic logic [7:0] rom_byte(input int unsigned addr);
    logic [7:0] b;
    case (addr)
      0:       b = 8'hA0;
      1:       b = 8'h05;
      2:       b = 8'hA4;
      3:       b = 8'h03;
      4:       b = 8'h11;
      5:       b = 8'h21;
      6:       b = 8'h99;
      7:       b = 8'h2A;
      8:       b = 8'hC0;
      9:       b = 8'h0C;
      12:      b = 8'hD0;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for opcodes ADD..SHR; carry is bit 8 of the 9-bit result
// (borrow for SUB, shifted-out bit for shifts).
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       carry
);

  logic [8:0] wide;

  always_comb begin
    wide = {1'b0, b};
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_NOT:  wide = {1'b0, ~b};
      OP_SHL:  wide = {b[7], b[6:0], 1'b0};
      OP_SHR:  wide = {b[0], 1'b0, b[7:1]};
      default: wide = {1'b0, b};
    endcase
  end

  assign result = wide[7:0];
  assign carry  = wide[8];

endmodule

// File: rtl/cpu_core.sv
// Board-level 8-bit multi-cycle CPU running a fixed ROM program, with its
// architectural state shown on 8 LEDs through a scanned page selector.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int SCAN_DIV  = 16,
  parameter int ROM_DEPTH = 32
) (
  input  logic       Clk,
  input  logic       SW,
  input  logic       ALU_F,
  output logic [7:0] led,
  output logic [2:0] which,
  output logic       shine
);

  localparam int PC_W  = $clog2(ROM_DEPTH);
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [7:0] rom [ROM_DEPTH];

  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    assign rom[gi] = rom_byte(gi);
  end

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [7:0]      ir_reg, ir_next;
  logic [7:0]      alr_reg, alr_next;
  logic            z_reg, z_next;
  logic            c_reg, c_next;
  logic            h_reg, h_next;
  logic [7:0]      regs_reg [4];
  logic [7:0]      regs_next [4];

  logic [DIV_W-1:0] div_reg;
  logic [2:0]       page_reg;

  logic [7:0] rom_q;
  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic [7:0] page_val;

  assign rom_q = rom[pc_reg];
  assign op    = ir_reg[7:4];
  assign rd    = ir_reg[3:2];
  assign rs    = ir_reg[1:0];

  cpu_alu u_alu (
    .op     (op),
    .a      (regs_reg[rd]),
    .b      (regs_reg[rs]),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    alr_next   = alr_reg;
    z_next     = z_reg;
    c_next     = c_reg;
    h_next     = h_reg;
    for (int i = 0; i < 4; i++) regs_next[i] = regs_reg[i];

    case (state_reg)
      ST_FETCH: begin
        ir_next    = rom_q;
        pc_next    = pc_reg + 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
            regs_next[rd] = alu_result;
            alr_next      = alu_result;
            z_next        = (alu_result == 8'h00);
            c_next        = alu_carry;
          end
          OP_MOV:                 regs_next[rd] = regs_reg[rs];
          OP_LDI, OP_JMP, OP_JZ:  state_next = ST_OPND;
          OP_HALT: begin
            h_next     = 1'b1;
            state_next = ST_HALT;
          end
          default: ;
        endcase
      end
      ST_OPND: begin
        state_next = ST_FETCH;
        case (op)
          OP_LDI: begin
            regs_next[rd] = rom_q;
            pc_next       = pc_reg + 1'b1;
          end
          OP_JMP: pc_next = rom_q[PC_W-1:0];
          // A not-taken branch still has to step over its operand byte.
          OP_JZ:  pc_next = z_reg ? rom_q[PC_W-1:0] : pc_reg + 1'b1;
          default: ;
        endcase
      end
      ST_HALT: ;
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!SW) begin
      state_reg <= ST_FETCH;
      pc_reg    <= '0;
      ir_reg    <= '0;
      alr_reg   <= '0;
      z_reg     <= 1'b0;
      c_reg     <= 1'b0;
      h_reg     <= 1'b0;
      for (int i = 0; i < 4; i++) regs_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      alr_reg   <= alr_next;
      z_reg     <= z_next;
      c_reg     <= c_next;
      h_reg     <= h_next;
      for (int i = 0; i < 4; i++) regs_reg[i] <= regs_next[i];
    end
  end

  // SCAN_DIV is a power of two, so the divider simply wraps.
  always_ff @(posedge Clk) begin
    if (!SW) begin
      div_reg  <= '0;
      page_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
      if (&div_reg) page_reg <= page_reg + 1'b1;
    end
  end

  always_comb begin
    page_val = 8'h00;
    case (page_reg)
      PAGE_R0, PAGE_R1, PAGE_R2, PAGE_R3: page_val = regs_reg[page_reg[1:0]];
      PAGE_PC:    page_val = 8'(pc_reg);
      PAGE_IR:    page_val = ir_reg;
      PAGE_ALR:   page_val = alr_reg;
      PAGE_FLAGS: page_val = {5'b0, h_reg, c_reg, z_reg};
      default:    page_val = 8'h00;
    endcase
  end

  assign led   = ALU_F ? alr_reg  : page_val;
  assign which = ALU_F ? PAGE_ALR : page_reg;
  assign shine = h_reg & page_reg[0];

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: retirement scoreboard on architectural state plus
// directed checks of reset, display scanning, ALU pinning and halt blink.
module tb_cpu_core;
  import cpu_pkg::*;

  logic       Clk = 1'b0;
  logic       SW = 1'b0;
  logic       ALU_F = 1'b0;
  logic [7:0] led;
  logic [2:0] which;
  logic       shine;

  cpu_core #(.SCAN_DIV(16), .ROM_DEPTH(32)) dut (
    .Clk   (Clk),
    .SW    (SW),
    .ALU_F (ALU_F),
    .led   (led),
    .which (which),
    .shine (shine)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // {R0,R1,R2,R3, 3'b0,PC, ALR, 5'b0,H,C,Z}
  logic [55:0] exp_q [$];
  state_t      prev_state;
  logic        sw_q = 1'b0;

  task automatic push_exp(input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] r3,
                          input logic [4:0] pc, input logic [7:0] alr,
                          input logic h, input logic c, input logic z);
    exp_q.push_back({r0, r1, r2, r3, 3'b0, pc, alr, 5'b0, h, c, z});
  endtask

  task automatic push_program;
    push_exp(8'h05, 8'h00, 8'h00, 8'h00, 5'd2,  8'h00, 1'b0, 1'b0, 1'b0); // LDI R0,5
    push_exp(8'h05, 8'h03, 8'h00, 8'h00, 5'd4,  8'h00, 1'b0, 1'b0, 1'b0); // LDI R1,3
    push_exp(8'h08, 8'h03, 8'h00, 8'h00, 5'd5,  8'h08, 1'b0, 1'b0, 1'b0); // ADD
    push_exp(8'h05, 8'h03, 8'h00, 8'h00, 5'd6,  8'h05, 1'b0, 1'b0, 1'b0); // SUB
    push_exp(8'h05, 8'h03, 8'h03, 8'h00, 5'd7,  8'h05, 1'b0, 1'b0, 1'b0); // MOV
    push_exp(8'h05, 8'h03, 8'h00, 8'h00, 5'd8,  8'h00, 1'b0, 1'b0, 1'b1); // SUB R2,R2
    push_exp(8'h05, 8'h03, 8'h00, 8'h00, 5'd12, 8'h00, 1'b0, 1'b0, 1'b1); // JZ taken
    push_exp(8'h05, 8'h03, 8'h00, 8'h00, 5'd13, 8'h00, 1'b1, 1'b0, 1'b1); // HALT
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge Clk);
    chk(name, 16'(exp_q.size()), 16'd0);
  endtask

  task automatic check_page(input logic [2:0] p, input logic [7:0] exp);
    int i;
    for (i = 0; i < 200 && which != p; i++) @(negedge Clk);
    chk($sformatf("page%0d_reached", p), 16'(which), 16'(p));
    chk($sformatf("page%0d_led", p), 16'(led), 16'(exp));
  endtask

  // Monitor: a retirement is the FSM arriving at FETCH or HALT during a run.
  always @(posedge Clk) sw_q <= SW;

  always @(negedge Clk) begin
    logic [55:0] obs;
    logic [55:0] exp;
    if (sw_q && dut.state_reg != prev_state &&
        (dut.state_reg == ST_FETCH || dut.state_reg == ST_HALT)) begin
      obs = {dut.regs_reg[0], dut.regs_reg[1], dut.regs_reg[2], dut.regs_reg[3],
             3'b0, dut.pc_reg, dut.alr_reg, 5'b0, dut.h_reg, dut.c_reg, dut.z_reg};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL retire_unexpected: got %h expected no retirement", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          n_bad++;
          $display("FAIL retire: got %h expected %h", obs, exp);
        end else begin
          $display("ok   retire: state %h", obs);
        end
      end
    end
    prev_state <= dut.state_reg;
  end

  initial begin
    logic       s0;
    logic [2:0] w0;
    int         cnt;
    int         n_opnd;

    // Reset held for three clocks.
    SW = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_led",   16'(led),   16'h00);
    chk("rst_which", 16'(which), 16'h0);
    chk("rst_shine", 16'(shine), 16'h0);
    chk("rst_pc",    16'(dut.pc_reg), 16'h0);

    // Full program run to HALT.
    push_program();
    SW = 1'b1;
    @(negedge Clk);
    chk("run1_led_first", 16'(led), 16'h00);
    wait_empty("run1_drained");
    chk("halted_state", 16'(dut.state_reg), 16'(ST_HALT));

    // Blink period while halted.
    s0 = shine;
    for (cnt = 0; cnt < 40 && shine == s0; cnt++) @(negedge Clk);
    s0 = shine;
    cnt = 0;
    for (int i = 0; i < 40 && shine == s0; i++) begin
      @(negedge Clk);
      cnt++;
    end
    chk("shine_period", 16'(cnt), 16'd16);

    // ALU page pinned.
    ALU_F = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat (9) @(negedge Clk);
      chk("pin_which", 16'(which), 16'h6);
      chk("pin_led",   16'(led),   16'h00);
    end
    ALU_F = 1'b0;
    #1;
    w0 = which;
    for (int i = 0; i < 40 && which == w0; i++) @(negedge Clk);
    chk("scan_resume", 16'(which), 16'(3'(w0 + 3'd1)));

    // Every page while halted.
    check_page(3'd0, 8'h05);
    check_page(3'd1, 8'h03);
    check_page(3'd2, 8'h00);
    check_page(3'd3, 8'h00);
    check_page(3'd4, 8'h0D);
    check_page(3'd5, 8'hD0);
    check_page(3'd6, 8'h00);
    check_page(3'd7, 8'h05);

    // Restart, then reset during the operand cycle of the second LDI.
    @(negedge Clk);
    SW = 1'b0;
    @(negedge Clk);
    push_exp(8'h05, 8'h00, 8'h00, 8'h00, 5'd2, 8'h00, 1'b0, 1'b0, 1'b0);
    SW = 1'b1;
    n_opnd = 0;
    for (int i = 0; i < 50 && n_opnd < 2; i++) begin
      @(negedge Clk);
      if (dut.state_reg == ST_OPND) n_opnd++;
    end
    chk("mid_in_opnd", 16'(dut.state_reg), 16'(ST_OPND));
    chk("mid_ir_ldi",  16'(dut.ir_reg), 16'hA4);
    chk("mid_scb_empty", 16'(exp_q.size()), 16'd0);
    SW = 1'b0;
    @(negedge Clk);
    chk("mid_state", 16'(dut.state_reg), 16'(ST_FETCH));
    chk("mid_pc",    16'(dut.pc_reg), 16'h0);
    chk("mid_r0",    16'(dut.regs_reg[0]), 16'h0);
    chk("mid_ir",    16'(dut.ir_reg), 16'h0);
    chk("mid_led",   16'(led),   16'h00);
    chk("mid_which", 16'(which), 16'h0);
    chk("mid_shine", 16'(shine), 16'h0);

    // Rerun must reproduce the same trace.
    push_program();
    SW = 1'b1;
    wait_empty("run2_drained");
    chk("run2_halted", 16'(dut.h_reg), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
